i2s_rx: RTL
===========

Name: i2s_rx

Overview:
I2S receiver and deserialiser; the receive-side counterpart of the team's I2S transmitter. It samples sdata on the rising edge of an externally supplied bit clock and frames each channel slot with ws, applying the standard 1-bit MSB delay. It presents each complete left/right sample pair to the downstream audio datapath, which runs in the same sclk domain, through a valid/ready handshake. It also flags framing errors and overruns.

Parameters:
AUDIO_DW, 16, bits per captured sample (MSB first); range 8..32.
CNT_W, 6, slot bit-counter width; the counter saturates at 2^CNT_W-1.

Ports:
sclk  input  1  bit clock; all logic on posedge sclk.
rst  input  1  asynchronous, active-low reset.
ws  input  1  word select from transmitter (0 = left, 1 = right); changes on negedge.
sdata  input  1  serial data from transmitter; changes on negedge.
out_left  output  AUDIO_DW  captured left sample.
out_right  output  AUDIO_DW  captured right sample.
out_valid  output  1  out_left/out_right hold a new pair.
out_ready  input  1  sink accepts the pair when out_valid && out_ready.
frame_err  output  1  one-cycle pulse: slot ended before AUDIO_DW bits were captured.
overrun  output  1  one-cycle pulse: a new pair was dropped because the previous pair was unaccepted.

Behaviour:
- Reset (rst=0, async): out_left=0, out_right=0, out_valid=0, frame_err=0, overrun=0, state=SYNC, ws_d=1, armed=0, bit_cnt=0, shift=0, left_hold=0, left_ok=0.
- ws_d is ws registered each posedge. armed is set on the first posedge after reset release. Edge = armed && (ws != ws_d).
- Slot timing: the edge posedge is the delay bit. It sets bit_cnt=1 and its sdata is ignored. Posedges with bit_cnt 2..AUDIO_DW+1 shift sdata in MSB first: shift <= {shift[AUDIO_DW-2:0], sdata}. Bits beyond AUDIO_DW+1 are ignored (zero padding). bit_cnt increments on every non-edge posedge and saturates.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC: a falling edge (ws_d=1, ws=0) moves to LEFT. A rising edge stays in SYNC. No capture occurs in SYNC.
  - LEFT: a rising edge moves to RIGHT. On the posedge with bit_cnt==AUDIO_DW+1, left_hold <= completed word and left_ok <= 1.
  - RIGHT: a falling edge moves to LEFT. On the posedge with bit_cnt==AUDIO_DW+1, if left_ok, the pair is complete, and left_ok <= 0.
- Pair output (same posedge the right LSB is sampled):
  - If !out_valid, or out_ready is high that cycle: out_left <= left_hold, out_right <= completed word, out_valid <= 1.
  - Otherwise: pair dropped, held outputs unchanged, overrun pulses 1 cycle.
- Handshake: out_valid deasserts on the posedge where out_valid && out_ready, unless a new pair loads on that same edge (simultaneous accept and load leaves out_valid=1 with the new data). While out_valid && !out_ready, out_left and out_right are stable.
- Short slot: an edge in LEFT or RIGHT with bit_cnt < AUDIO_DW+1 pulses frame_err for 1 cycle, clears left_ok and discards the partial word. The state transition still follows the ws edge.
- Latency: out_valid rises 1 posedge after the right-channel LSB bit period begins (sampled on that posedge's registered update). This is AUDIO_DW+1 posedges after the right-slot ws edge.
- Reset mid-frame: all state is cleared asynchronously. After release, the receiver returns to SYNC, and the first pair output requires a full left slot followed by a full right slot.

Decomposition:
- Package i2s_pkg: typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t; localparam I2S_DEFAULT_DW = 16; localparam I2S_CNT_W = 6.
- Sub-module i2s_ws_edge: ws_d register, armed flag, and rise/fall pulse outputs. It is reusable by the transmitter bench monitor.

Test Plan:
- DW=16, 32-bit slots, left=16'hA5C3, right=16'h1234, out_ready=1 -> after the right slot's 17th posedge, out_valid=1, out_left=A5C3, out_right=1234; no frame_err or overrun.
- Reset released while ws=1 mid-right-slot -> no output for that partial frame; the first pair appears only after a complete left+right frame.
- Slot length exactly 17 sclks (AUDIO_DW+1) for both channels, values 16'hFFFF/16'h0001 -> captured correctly, no frame_err.
- Left slot cut to 10 bits by an early ws edge -> frame_err pulses once, no out_valid for that frame; the next good frame (16'h0F0F/16'hF0F0) is delivered.
- out_ready=0 for 3 frames starting with pair 16'h1111/16'h2222 -> outputs hold 1111/2222, overrun pulses twice; raising out_ready on the 4th frame's load edge gives out_valid=1 with the new pair.
- Back-to-back frames with out_ready=1 throughout -> exactly one out_valid-handled transfer per frame, data in order, out_valid never drops between simultaneous accept and load.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive path.
package i2s_pkg;

    // Receiver framing state: hunting for a left slot, or inside a channel slot.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_rx_state_t;

    localparam int I2S_DEFAULT_DW = 16;
    localparam int I2S_CNT_W      = 6;

endpackage

// File: rtl/i2s_ws_edge.sv
// Word-select edge detector: registers ws and flags rising/falling transitions.
// The first posedge after reset only arms the detector, so a ws level that differs
// from the reset value of the delayed copy never looks like an edge.
module i2s_ws_edge (
    input  logic i_sclk,
    input  logic i_rst_n,
    input  logic i_ws,
    output logic o_rise,
    output logic o_fall
);

    logic r_ws_d;
    logic r_armed;

    // Delayed copy of ws and the arm flag.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ws_d  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_ws_d  <= i_ws;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = r_armed &&  i_ws && !r_ws_d;
    assign o_fall = r_armed && !i_ws &&  r_ws_d;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: frames left/right slots on ws edges with the 1-bit MSB delay,
// captures AUDIO_DW bits MSB first, and hands out complete pairs via valid/ready.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = I2S_DEFAULT_DW,
    parameter int CNT_W    = I2S_CNT_W
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                ws,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] out_left,
    output logic [AUDIO_DW-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_err,
    output logic                overrun
);

    // Slot position of the LSB: the edge posedge is position 1 (delay bit).
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(AUDIO_DW + 1);

    i2s_rx_state_t r_state;
    i2s_rx_state_t w_state_next;

    logic                w_rise;
    logic                w_fall;
    logic                w_edge;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_slot_pos;
    logic [AUDIO_DW-2:0] r_shift;
    logic [AUDIO_DW-1:0] w_word;
    logic                w_in_data;
    logic                w_slot_end;
    logic                w_short;
    logic                w_left_done;
    logic                w_pair_done;
    logic [AUDIO_DW-1:0] r_left_hold;
    logic                r_left_ok;
    logic [AUDIO_DW-1:0] r_out_left;
    logic [AUDIO_DW-1:0] r_out_right;
    logic                r_out_valid;
    logic                r_frame_err;
    logic                r_overrun;

    i2s_ws_edge u_ws_edge (
        .i_sclk  (sclk),
        .i_rst_n (rst),
        .i_ws    (ws),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge = w_rise || w_fall;

    // Position of the current posedge within its slot; saturates on long slots.
    always_comb begin
        w_slot_pos = r_bit_cnt;
        if (w_edge) begin
            w_slot_pos = CNT_W'(1);
        end else if (r_bit_cnt != '1) begin
            w_slot_pos = r_bit_cnt + CNT_W'(1);
        end
    end

    assign w_word      = {r_shift, sdata};
    assign w_in_data   = !w_edge && (w_slot_pos >= CNT_W'(2)) && (w_slot_pos <= LAST_POS);
    assign w_slot_end  = !w_edge && (w_slot_pos == LAST_POS);
    assign w_short     = w_edge && (r_state != SYNC) && (r_bit_cnt < LAST_POS);
    assign w_left_done = w_slot_end && (r_state == LEFT);
    assign w_pair_done = w_slot_end && (r_state == RIGHT) && r_left_ok;

    // FSM state register.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: transitions follow ws edges only; short slots still move on.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC:    if (w_fall) w_state_next = LEFT;
            LEFT:    if (w_rise) w_state_next = RIGHT;
            RIGHT:   if (w_fall) w_state_next = LEFT;
            default: w_state_next = SYNC;
        endcase
    end

    // Slot counter, shifter, left holding register and error pulses.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_bit_cnt   <= w_slot_pos;
            r_frame_err <= w_short;
            // Edge discards any partial word; padding bits past the LSB are ignored.
            if (w_edge) begin
                r_shift <= '0;
            end else if (w_in_data) begin
                r_shift <= w_word[AUDIO_DW-2:0];
            end
            if (w_short) begin
                r_left_ok <= 1'b0;
            end else if (w_left_done) begin
                r_left_hold <= w_word;
                r_left_ok   <= 1'b1;
            end else if (w_pair_done) begin
                r_left_ok <= 1'b0;
            end
        end
    end

    // Output pair register: load when free or being accepted, else drop and flag overrun.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_out_left  <= '0;
            r_out_right <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_pair_done) begin
                if (!r_out_valid || out_ready) begin
                    r_out_left  <= r_left_hold;
                    r_out_right <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_left  = r_out_left;
    assign out_right = r_out_right;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
